pipe_stage_ctrl: RTL and testbench

//   Parametrised pipeline control for the CPU: valid registers, allow_in/over handshake chain, inter-stage bus latches.

---
 rtl/pipe_stage_ctrl_if.sv | 30 +++
 rtl/pipe_stage_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_ctrl_if.sv
// Handshake and bus bundle between the pipeline stage modules and pipe_stage_ctrl.
// The master modport is the stage side; the slave modport is the controller.
interface pipe_stage_ctrl_if #(
    parameter int STAGES = 5,
    parameter int BUS_W  = 192,
    parameter int CNT_W  = 32
);
    logic                          fetch_en;
    logic [STAGES-1:0]             stage_over;
    logic [STAGES-1:0]             flush_mask;
    logic [(STAGES-1)*BUS_W-1:0]   stage_bus;
    logic                          cnt_clr;
    logic [STAGES-1:0]             stage_valid;
    logic [STAGES-1:0]             allow_in;
    logic [STAGES-2:0]             fire;
    logic                          next_fetch;
    logic [(STAGES-1)*BUS_W-1:0]   bus_r;
    logic [STAGES*CNT_W-1:0]       stall_cnt;
    logic [CNT_W-1:0]              flush_cnt;

    modport master (
        output fetch_en, stage_over, flush_mask, stage_bus, cnt_clr,
        input  stage_valid, allow_in, fire, next_fetch, bus_r, stall_cnt, flush_cnt
    );

    modport slave (
        input  fetch_en, stage_over, flush_mask, stage_bus, cnt_clr,
        output stage_valid, allow_in, fire, next_fetch, bus_r, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Parametrised pipeline control: per-stage valid bits, allow_in/over handshake chain,
// inter-stage bus latches, per-stage flush and saturating stall/flush counters.
module pipe_stage_ctrl #(
    parameter int STAGES = 5,
    parameter int BUS_W  = 192,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             resetn,
    pipe_stage_ctrl_if.slave ctrl
);
    localparam int NB = (STAGES-1)*BUS_W;

    logic [STAGES-1:0]       stage_valid_r;
    logic [NB-1:0]           bus_q_r;
    logic [STAGES*CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0]        flush_cnt_r;

    logic [STAGES-1:0]       over_q_s;
    logic [STAGES-1:0]       allow_in_s;
    logic [STAGES-2:0]       fire_s;
    logic [STAGES-1:0]       stall_s;
    logic                    flush_any_s;
    logic                    chain_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Handshake chain: allow_in ripples from writeback back towards fetch in one cycle.
    always_comb begin
        over_q_s    = stage_valid_r & ctrl.stage_over;
        flush_any_s = |ctrl.flush_mask;
        allow_in_s  = '0;
        fire_s      = '0;
        stall_s     = '0;
        chain_s     = ~stage_valid_r[STAGES-1] | over_q_s[STAGES-1];
        allow_in_s[STAGES-1] = chain_s;
        for (int i = STAGES-2; i >= 1; i--) begin
            chain_s       = ~stage_valid_r[i] | (over_q_s[i] & chain_s);
            allow_in_s[i] = chain_s;
        end
        // A flush anywhere redirects fetch, so stage 0 is released regardless of downstream.
        allow_in_s[0] = (over_q_s[0] & chain_s) | flush_any_s;
        for (int i = 0; i <= STAGES-2; i++) begin
            fire_s[i]  = over_q_s[i] & allow_in_s[i+1];
            stall_s[i] = stage_valid_r[i] & ~fire_s[i];
        end
        stall_s[STAGES-1] = stage_valid_r[STAGES-1] & ~over_q_s[STAGES-1];
    end

    // Valid registers: flush of a stage beats an incoming handoff; stage 0 tracks fetch_en.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stage_valid_r <= '0;
        end else begin
            stage_valid_r[0] <= ctrl.fetch_en;
            for (int i = 1; i < STAGES; i++) begin
                if (ctrl.flush_mask[i]) begin
                    stage_valid_r[i] <= 1'b0;
                end else if (allow_in_s[i]) begin
                    stage_valid_r[i] <= fire_s[i-1];
                end else begin
                    stage_valid_r[i] <= stage_valid_r[i];
                end
            end
        end
    end

    // Bus latches capture on every handoff, even when the receiving stage is being flushed.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus_q_r <= '0;
        end else begin
            for (int i = 0; i < STAGES-1; i++) begin
                if (fire_s[i]) begin
                    bus_q_r[i*BUS_W +: BUS_W] <= ctrl.stage_bus[i*BUS_W +: BUS_W];
                end else begin
                    bus_q_r[i*BUS_W +: BUS_W] <= bus_q_r[i*BUS_W +: BUS_W];
                end
            end
        end
    end

    // Saturating stall and flush counters; a clear request wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else if (ctrl.cnt_clr) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (stall_s[i]) begin
                    stall_cnt_r[i*CNT_W +: CNT_W] <= sat_inc(stall_cnt_r[i*CNT_W +: CNT_W]);
                end else begin
                    stall_cnt_r[i*CNT_W +: CNT_W] <= stall_cnt_r[i*CNT_W +: CNT_W];
                end
            end
            if (flush_any_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign ctrl.stage_valid = stage_valid_r;
    assign ctrl.allow_in    = allow_in_s;
    assign ctrl.fire        = fire_s;
    assign ctrl.next_fetch  = allow_in_s[0];
    assign ctrl.bus_r       = bus_q_r;
    assign ctrl.stall_cnt   = stall_cnt_r;
    assign ctrl.flush_cnt   = flush_cnt_r;
endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Scoreboard bench for pipe_stage_ctrl: a 5-stage and a 3-stage instance, directed vectors,
// expectations queued by the driver and checked by an independent negedge monitor.
module tb_pipe_stage_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn5 = 1'b0;
    logic resetn3 = 1'b0;
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    pipe_stage_ctrl_if #(.STAGES(5), .BUS_W(8), .CNT_W(4)) if5 ();
    pipe_stage_ctrl_if #(.STAGES(3), .BUS_W(8), .CNT_W(4)) if3 ();

    pipe_stage_ctrl #(.STAGES(5), .BUS_W(8), .CNT_W(4)) dut5 (.clk(clk), .resetn(resetn5), .ctrl(if5));
    pipe_stage_ctrl #(.STAGES(3), .BUS_W(8), .CNT_W(4)) dut3 (.clk(clk), .resetn(resetn3), .ctrl(if3));

    typedef enum int {K_VALID, K_ALLOW, K_FIRE, K_NF, K_BUS, K_STALL, K_FCNT, K_VALID3, K_ALLOW3, K_BUS3} kind_t;
    typedef struct {
        int          cyc;
        kind_t       kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [31:0] obs;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(input kind_t k, input int idx);
        case (k)
            K_VALID:  return 32'(if5.stage_valid);
            K_ALLOW:  return 32'(if5.allow_in);
            K_FIRE:   return 32'(if5.fire);
            K_NF:     return 32'(if5.next_fetch);
            K_BUS:    return 32'(if5.bus_r[idx*8 +: 8]);
            K_STALL:  return 32'(if5.stall_cnt[idx*4 +: 4]);
            K_FCNT:   return 32'(if5.flush_cnt);
            K_VALID3: return 32'(if3.stage_valid);
            K_ALLOW3: return 32'(if3.allow_in);
            K_BUS3:   return 32'(if3.bus_r[idx*8 +: 8]);
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic string kname(input kind_t k);
        case (k)
            K_VALID:  return "valid5";
            K_ALLOW:  return "allow_in5";
            K_FIRE:   return "fire5";
            K_NF:     return "next_fetch5";
            K_BUS:    return "bus_r5";
            K_STALL:  return "stall_cnt5";
            K_FCNT:   return "flush_cnt5";
            K_VALID3: return "valid3";
            K_ALLOW3: return "allow_in3";
            K_BUS3:   return "bus_r3";
            default:  return "unknown";
        endcase
    endfunction

    // Monitor: compare every expectation due in this cycle against the DUT outputs.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            obs = observe(cur.kind, cur.idx);
            n_cmp++;
            if (cur.cyc != cyc || obs !== cur.exp) begin
                n_err++;
                $display("FAIL %s[%0d] cyc %0d: got %0h expected %0h", kname(cur.kind), cur.idx, cyc, obs, cur.exp);
            end
        end
    end

    task automatic drive5(input logic rst, input logic fe, input logic [4:0] ov, input logic [4:0] fl,
                          input logic [31:0] bus, input logic clr);
        @(posedge clk);
        #1;
        resetn5        = rst;
        if5.fetch_en   = fe;
        if5.stage_over = ov;
        if5.flush_mask = fl;
        if5.stage_bus  = bus;
        if5.cnt_clr    = clr;
    endtask

    task automatic drive3(input logic rst, input logic fe, input logic [2:0] ov, input logic [2:0] fl,
                          input logic [15:0] bus, input logic clr);
        @(posedge clk);
        #1;
        resetn3        = rst;
        if3.fetch_en   = fe;
        if3.stage_over = ov;
        if3.flush_mask = fl;
        if3.stage_bus  = bus;
        if3.cnt_clr    = clr;
    endtask

    task automatic expect_v(input kind_t k, input int idx, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.kind = k;
        e.idx  = idx;
        e.exp  = v;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] fill_v[6];
        fill_v[0] = 32'h00; fill_v[1] = 32'h01; fill_v[2] = 32'h03;
        fill_v[3] = 32'h07; fill_v[4] = 32'h0F; fill_v[5] = 32'h1F;

        if5.fetch_en = 1'b0; if5.stage_over = 5'h00; if5.flush_mask = 5'h00;
        if5.stage_bus = 32'h0; if5.cnt_clr = 1'b0;
        if3.fetch_en = 1'b0; if3.stage_over = 3'h0; if3.flush_mask = 3'h0;
        if3.stage_bus = 16'h0; if3.cnt_clr = 1'b0;

        // Reset held for three edges
        drive5(1'b0, 1'b0, 5'h00, 5'h00, 32'h0, 1'b0);
        drive5(1'b0, 1'b0, 5'h00, 5'h00, 32'h0, 1'b0);
        expect_v(K_VALID, 0, 32'h00);
        expect_v(K_ALLOW, 0, 32'h1E);
        expect_v(K_NF, 0, 32'h0);
        for (int i = 0; i < 4; i++) expect_v(K_BUS, i, 32'h0);
        for (int i = 0; i < 5; i++) expect_v(K_STALL, i, 32'h0);
        expect_v(K_FCNT, 0, 32'h0);
        drive5(1'b0, 1'b0, 5'h00, 5'h00, 32'h0, 1'b0);
        expect_v(K_VALID, 0, 32'h00);

        // Fill: one stage per cycle
        for (int k = 0; k < 6; k++) begin
            drive5(1'b1, 1'b1, 5'h1F, 5'h00, 32'h44332211, 1'b0);
            expect_v(K_VALID, 0, fill_v[k]);
            if (k == 1) expect_v(K_BUS, 0, 32'h00);
            if (k == 2) expect_v(K_BUS, 0, 32'h11);
        end
        expect_v(K_ALLOW, 0, 32'h1F);
        expect_v(K_NF, 0, 32'h1);
        expect_v(K_BUS, 0, 32'h11); expect_v(K_BUS, 1, 32'h22);
        expect_v(K_BUS, 2, 32'h33); expect_v(K_BUS, 3, 32'h44);

        // Back-pressure: stage 2 not over for 3 cycles
        drive5(1'b1, 1'b1, 5'h1B, 5'h00, 32'hDDCCBBAA, 1'b0);
        expect_v(K_ALLOW, 0, 32'h18); expect_v(K_FIRE, 0, 32'h8); expect_v(K_NF, 0, 32'h0);
        drive5(1'b1, 1'b1, 5'h1B, 5'h00, 32'hDDCCBBAA, 1'b0);
        expect_v(K_VALID, 0, 32'h17); expect_v(K_ALLOW, 0, 32'h18); expect_v(K_FIRE, 0, 32'h0);
        drive5(1'b1, 1'b1, 5'h1B, 5'h00, 32'hDDCCBBAA, 1'b0);
        expect_v(K_VALID, 0, 32'h07);
        drive5(1'b1, 1'b1, 5'h1F, 5'h00, 32'h0, 1'b0);
        expect_v(K_VALID, 0, 32'h07);
        for (int i = 0; i < 3; i++) expect_v(K_STALL, i, 32'h3);
        expect_v(K_STALL, 3, 32'h0); expect_v(K_STALL, 4, 32'h0);
        expect_v(K_BUS, 0, 32'h11); expect_v(K_BUS, 1, 32'h22);
        expect_v(K_BUS, 2, 32'h33); expect_v(K_BUS, 3, 32'hDD);
        expect_v(K_ALLOW, 0, 32'h1F); expect_v(K_FIRE, 0, 32'h7);
        drive5(1'b1, 1'b1, 5'h1F, 5'h00, 32'h0, 1'b0);
        expect_v(K_VALID, 0, 32'h0F);

        // Flush stages 1..3
        drive5(1'b1, 1'b1, 5'h1F, 5'h0E, 32'h0, 1'b0);
        expect_v(K_VALID, 0, 32'h1F); expect_v(K_ALLOW, 0, 32'h1F);
        expect_v(K_NF, 0, 32'h1); expect_v(K_FIRE, 0, 32'hF);
        drive5(1'b1, 1'b1, 5'h1F, 5'h00, 32'h0, 1'b0);
        expect_v(K_VALID, 0, 32'h11); expect_v(K_FCNT, 0, 32'h1);

        // Handoff into a stage flushed in the same cycle still latches the bus
        drive5(1'b1, 1'b1, 5'h1F, 5'h04, 32'h0000A500, 1'b0);
        expect_v(K_VALID, 0, 32'h03); expect_v(K_FIRE, 0, 32'h3);
        drive5(1'b1, 1'b1, 5'h1F, 5'h00, 32'h0, 1'b0);
        expect_v(K_VALID, 0, 32'h03); expect_v(K_BUS, 1, 32'hA5);
        expect_v(K_FCNT, 0, 32'h2); expect_v(K_STALL, 2, 32'h3);
        drive5(1'b1, 1'b1, 5'h1F, 5'h00, 32'h0, 1'b0);
        expect_v(K_VALID, 0, 32'h07);
        drive5(1'b1, 1'b1, 5'h1F, 5'h00, 32'h0, 1'b0);
        expect_v(K_VALID, 0, 32'h0F);

        // Writeback stalled 20 cycles: counters saturate
        for (int k = 0; k < 20; k++) begin
            drive5(1'b1, 1'b1, 5'h0F, 5'h00, 32'h0, 1'b0);
            if (k == 0) begin
                expect_v(K_VALID, 0, 32'h1F); expect_v(K_ALLOW, 0, 32'h00);
                expect_v(K_NF, 0, 32'h0); expect_v(K_FIRE, 0, 32'h0);
            end
            if (k == 14) expect_v(K_STALL, 4, 32'hE);
            if (k == 15) expect_v(K_STALL, 4, 32'hF);
        end
        drive5(1'b1, 1'b1, 5'h0F, 5'h00, 32'h0, 1'b1);
        expect_v(K_STALL, 4, 32'hF); expect_v(K_STALL, 0, 32'hF);
        expect_v(K_STALL, 3, 32'hF); expect_v(K_VALID, 0, 32'h1F);
        drive5(1'b1, 1'b1, 5'h0F, 5'h00, 32'h0, 1'b0);
        expect_v(K_STALL, 4, 32'h0); expect_v(K_STALL, 0, 32'h0); expect_v(K_FCNT, 0, 32'h0);
        drive5(1'b1, 1'b1, 5'h1F, 5'h00, 32'h0, 1'b0);
        expect_v(K_STALL, 4, 32'h1); expect_v(K_STALL, 0, 32'h1);

        // Three-stage instance: fill then reset mid-stream
        drive3(1'b1, 1'b1, 3'h7, 3'h0, 16'h2211, 1'b0);
        expect_v(K_VALID3, 0, 32'h0);
        drive3(1'b1, 1'b1, 3'h7, 3'h0, 16'h2211, 1'b0);
        expect_v(K_VALID3, 0, 32'h1);
        drive3(1'b1, 1'b1, 3'h7, 3'h0, 16'h2211, 1'b0);
        expect_v(K_VALID3, 0, 32'h3); expect_v(K_BUS3, 0, 32'h11);
        drive3(1'b0, 1'b1, 3'h7, 3'h0, 16'h2211, 1'b0);
        expect_v(K_VALID3, 0, 32'h7); expect_v(K_ALLOW3, 0, 32'h7);
        drive3(1'b0, 1'b1, 3'h7, 3'h0, 16'h2211, 1'b0);
        expect_v(K_VALID3, 0, 32'h0); expect_v(K_ALLOW3, 0, 32'h6);
        expect_v(K_BUS3, 0, 32'h0); expect_v(K_BUS3, 1, 32'h0);

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
            n_err += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
